// File: rtl/capture_readout_pkg.sv
// Shared types and constants for the capture readout path.
package capture_readout_pkg;

  localparam int unsigned ADDR_W       = 18;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned SRAM_LAT_DEF = 2;
  localparam int unsigned SRAM_LAT_MAX = 7;
  localparam int unsigned LAT_W        = $clog2(SRAM_LAT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LOAD,
    ST_WAIT_STB,
    ST_FETCH,
    ST_PRESENT,
    ST_DONE
  } rd_state_t;

  // States in which a strobe edge is remembered for later service.
  function automatic logic holds_strobe(input rd_state_t s);
    return (s == ST_ARM) || (s == ST_LOAD) || (s == ST_FETCH) || (s == ST_PRESENT);
  endfunction

endpackage

// File: rtl/capture_readout_if.sv
// Capture/MCU/SRAM signal bundle for the readout block.
interface capture_readout_if #(
  parameter int unsigned ADDR_W = capture_readout_pkg::ADDR_W,
  parameter int unsigned DATA_W = capture_readout_pkg::DATA_W
);
  logic              Write_Ready;
  logic [ADDR_W-1:0] Stop_Addr;
  logic [ADDR_W-1:0] WIN_DATA;
  logic              Read_Start;
  logic              RD_STROBE;
  logic [DATA_W-1:0] SRAM_DATA_A;
  logic [DATA_W-1:0] SRAM_DATA_B;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_OE_n;
  logic [DATA_W-1:0] DATA_OUT;
  logic              Data_Valid;
  logic              Read_Busy;
  logic              Read_Done;
  logic              Overrun;

  // Readout block side.
  modport slave (
    input  Write_Ready, Stop_Addr, WIN_DATA, Read_Start, RD_STROBE, SRAM_DATA_A, SRAM_DATA_B,
    output SRAM_ADDR, SRAM_OE_n, DATA_OUT, Data_Valid, Read_Busy, Read_Done, Overrun
  );

  // Capture control / MCU / SRAM side.
  modport master (
    output Write_Ready, Stop_Addr, WIN_DATA, Read_Start, RD_STROBE, SRAM_DATA_A, SRAM_DATA_B,
    input  SRAM_ADDR, SRAM_OE_n, DATA_OUT, Data_Valid, Read_Busy, Read_Done, Overrun
  );
endinterface

// File: rtl/capture_readout_strobe_sync.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous MCU strobe.
module capture_readout_strobe_sync (
  input  logic CLK,
  input  logic nRST,
  input  logic async_in,
  output logic rise_c
);

  // [0] first sync stage, [1] second sync stage, [2] previous synced value
  logic [2:0] sync_q;

  // Shift the strobe through the synchroniser and history flop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/capture_readout.sv
// Replays a stopped capture window from sample SRAM to the MCU, oldest first,
// one sample per MCU read-strobe rising edge.
// Optional feature macro: READOUT_CHAN_B_EN (two samples per address, A then B).
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int unsigned SRAM_LAT = SRAM_LAT_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  capture_readout_if.slave bus
);

  rd_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic              pending_q;
  logic              oe_n_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic              strobe_rise_c;
  logic              need_fetch_c;
  logic              advance_c;
  logic [DATA_W-1:0] present_data_c;

  capture_readout_strobe_sync u_strobe_sync (
    .CLK      (CLK),
    .nRST     (nRST),
    .async_in (bus.RD_STROBE),
    .rise_c   (strobe_rise_c)
  );

`ifdef READOUT_CHAN_B_EN
  logic              chan_b_q;
  logic [DATA_W-1:0] b_data_q;

  // B sample is captured alongside A and replayed on the following strobe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      chan_b_q <= 1'b0;
      b_data_q <= '0;
    end else if (state_q == ST_LOAD) begin
      chan_b_q <= 1'b0;
    end else if (state_q == ST_PRESENT) begin
      chan_b_q <= ~chan_b_q;
      if (!chan_b_q) begin
        b_data_q <= bus.SRAM_DATA_B;
      end
    end
  end

  assign need_fetch_c   = ~chan_b_q;
  assign advance_c      = chan_b_q;
  assign present_data_c = chan_b_q ? b_data_q : bus.SRAM_DATA_A;
`else
  logic unused_chan_b;

  assign need_fetch_c   = 1'b1;
  assign advance_c      = 1'b1;
  assign present_data_c = bus.SRAM_DATA_A;
  assign unused_chan_b  = ^bus.SRAM_DATA_B;
`endif

  // Readout sequencer with registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      pending_q   <= 1'b0;
      oe_n_q      <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // One-deep strobe memory; a second edge while one is waiting is lost.
      if (strobe_rise_c && holds_strobe(state_q)) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Any strobe edge seen here is discarded, including one coincident with Read_Start.
          if (bus.Read_Start) begin
            state_q   <= ST_ARM;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
          end
        end

        ST_ARM: begin
          if (bus.Write_Ready) begin
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          addr_q      <= bus.Stop_Addr - bus.WIN_DATA + ADDR_W'(1);
          remaining_q <= bus.WIN_DATA;
          if (bus.WIN_DATA == '0) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pending_q <= 1'b0;
          end else begin
            state_q <= ST_WAIT_STB;
          end
        end

        ST_WAIT_STB: begin
          if (strobe_rise_c || pending_q) begin
            if (strobe_rise_c && pending_q) begin
              overrun_q <= 1'b1;
            end
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            if (need_fetch_c) begin
              state_q   <= ST_FETCH;
              oe_n_q    <= 1'b0;
              lat_cnt_q <= '0;
            end else begin
              state_q <= ST_PRESENT;
            end
          end
        end

        ST_FETCH: begin
          if (lat_cnt_q == LAT_W'(SRAM_LAT - 1)) begin
            state_q <= ST_PRESENT;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end

        ST_PRESENT: begin
          data_q  <= present_data_c;
          valid_q <= 1'b1;
          oe_n_q  <= 1'b1;
          if (advance_c) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            if (remaining_q == ADDR_W'(1)) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pending_q <= 1'b0;
            end else begin
              state_q <= ST_WAIT_STB;
            end
          end else begin
            state_q <= ST_WAIT_STB;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          oe_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.SRAM_ADDR  = addr_q;
  assign bus.SRAM_OE_n  = oe_n_q;
  assign bus.DATA_OUT   = data_q;
  assign bus.Data_Valid = valid_q;
  assign bus.Read_Busy  = busy_q;
  assign bus.Read_Done  = done_q;
  assign bus.Overrun    = overrun_q;

endmodule

// File: tb/tb_capture_readout.sv
// Scoreboard bench for capture_readout: stimulus pushes expected samples and
// fetch addresses; a negedge monitor pops and compares as the DUT presents them.
module tb_capture_readout;
  import capture_readout_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int          DEPTH = 1 << ADDR_W;
`ifdef READOUT_CHAN_B_EN
  localparam int          SPA   = 2;
`else
  localparam int          SPA   = 1;
`endif

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  capture_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  capture_readout #(.SRAM_LAT(LAT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_data[$];
  int                exp_addr[$];
  int                m_stop, m_win, m_idx;
  int                fetch_cnt = 0;
  int                oe_cnt    = 0;
  logic              dv_prev   = 1'b0;
  logic              oe_prev   = 1'b1;

  // SRAM contents as pure functions of address.
  function automatic logic [DATA_W-1:0] mem_a(input int a);
    return DATA_W'((a * 37) ^ (a >>> 7) ^ 90);
  endfunction

  function automatic logic [DATA_W-1:0] mem_b(input int a);
    return DATA_W'((a * 13) ^ (a >>> 3) ^ 165);
  endfunction

  // SRAM model: data is only good once OE_n has been low for LAT cycles.
  always @(posedge CLK) oe_cnt <= bus.SRAM_OE_n ? 0 : oe_cnt + 1;
  assign bus.SRAM_DATA_A = (oe_cnt >= int'(LAT)) ? mem_a(int'(bus.SRAM_ADDR)) : DATA_W'('hEE);
  assign bus.SRAM_DATA_B = (oe_cnt >= int'(LAT)) ? mem_b(int'(bus.SRAM_ADDR)) : DATA_W'('h11);

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each newly presented sample and each SRAM fetch address.
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.Data_Valid && !dv_prev) begin
        if (exp_data.size() == 0) check("unexpected_sample", int'(bus.DATA_OUT), -1);
        else check("sample_data", int'(bus.DATA_OUT), int'(exp_data.pop_front()));
      end
      if (!bus.SRAM_OE_n && oe_prev) begin
        fetch_cnt++;
        if (exp_addr.size() == 0) check("unexpected_fetch", int'(bus.SRAM_ADDR), -1);
        else check("fetch_addr", int'(bus.SRAM_ADDR), exp_addr.pop_front());
      end
    end
    dv_prev = bus.Data_Valid;
    oe_prev = bus.SRAM_OE_n;
  end

  // Reference: sample k of the window lives at (stop - win + 1 + k/SPA) mod depth.
  function automatic int model_addr(input int i);
    return ((m_stop - m_win + 1 + i) % DEPTH + DEPTH) % DEPTH;
  endfunction

  task automatic push_next();
    int a;
    a = model_addr(m_idx / SPA);
    if (m_idx % SPA == 0) begin
      exp_addr.push_back(a);
      exp_data.push_back(mem_a(a));
    end else begin
      exp_data.push_back(mem_b(a));
    end
    m_idx++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},    int'(bus.SRAM_ADDR),  0);
    check({tag, "_oe_n"},    int'(bus.SRAM_OE_n),  1);
    check({tag, "_data"},    int'(bus.DATA_OUT),   0);
    check({tag, "_valid"},   int'(bus.Data_Valid), 0);
    check({tag, "_busy"},    int'(bus.Read_Busy),  0);
    check({tag, "_done"},    int'(bus.Read_Done),  0);
    check({tag, "_overrun"}, int'(bus.Overrun),    0);
  endtask

  // Start a readout; optionally land a strobe edge on the same cycle as Read_Start.
  task automatic start_read(input int stop, input int win, input bit clash);
    @(negedge CLK);
    bus.Write_Ready = 1'b0;
    bus.Stop_Addr   = ADDR_W'(stop);
    bus.WIN_DATA    = ADDR_W'(win);
    if (clash) begin
      bus.RD_STROBE = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      bus.RD_STROBE = 1'b0;
    end
    bus.Read_Start = 1'b1;
    @(negedge CLK);
    bus.Read_Start = 1'b0;
    check("start_overrun_clear", int'(bus.Overrun), 0);
    check("start_done_clear", int'(bus.Read_Done), 0);
    repeat (2) @(negedge CLK);
    bus.Write_Ready = 1'b1;
    repeat (3) @(negedge CLK);
    m_stop = stop;
    m_win  = win;
    m_idx  = 0;
  endtask

  // Well-behaved MCU read: one strobe, wait for the sample, check pin-to-valid latency.
  task automatic strobe_and_wait(output bit ok);
    int lat;
    bit first_half;
    bit seen_low;
    first_half = (m_idx % SPA == 0);
    push_next();
    @(negedge CLK);
    bus.RD_STROBE = 1'b1;
    lat = 0;
    ok = 1'b0;
    seen_low = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge CLK);
      lat++;
      #1;
      if (!bus.Data_Valid) seen_low = 1'b1;
      else if (seen_low) ok = 1'b1;
    end
    if (ok) check("strobe_latency", lat, first_half ? int'(LAT) + 4 : 4);
    else check("strobe_timeout", lat, -1);
    @(negedge CLK);
    bus.RD_STROBE = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge CLK);
  endtask

  task automatic finish_window(input string tag);
    repeat (2) @(negedge CLK);
    check({tag, "_done"}, int'(bus.Read_Done), 1);
    check({tag, "_busy"}, int'(bus.Read_Busy), 0);
    check({tag, "_sb_empty"}, exp_data.size() + exp_addr.size(), 0);
  endtask

  task automatic read_window(input int stop, input int win, input bit clash);
    bit ok;
    start_read(stop, win, clash);
    for (int i = 0; i < win * SPA; i++) begin
      if (i == win * SPA - 1) check("done_not_early", int'(bus.Read_Done), 0);
      strobe_and_wait(ok);
      if (!ok) break;
      if (i == 0 && win * SPA > 1) check("busy_mid_read", int'(bus.Read_Busy), 1);
    end
    finish_window("window");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int f0;
    bus.Write_Ready = 1'b0;
    bus.Stop_Addr   = '0;
    bus.WIN_DATA    = '0;
    bus.Read_Start  = 1'b0;
    bus.RD_STROBE   = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic window and a window that wraps through the top of the address space.
    read_window(100, 10, 1'b0);
    read_window(3, 6, 1'b0);

    // Empty window: straight to done, no SRAM access.
    f0 = fetch_cnt;
    start_read(50, 0, 1'b0);
    repeat (2) @(negedge CLK);
    check("empty_done", int'(bus.Read_Done), 1);
    check("empty_busy", int'(bus.Read_Busy), 0);
    check("empty_no_fetch", fetch_cnt - f0, 0);
    check("empty_oe_n", int'(bus.SRAM_OE_n), 1);

    // Strobe edge coincident with Read_Start in DONE is discarded.
    read_window(200, 3, 1'b1);
    check("clash_no_overrun", int'(bus.Overrun), 0);

    // Burst of three edges: first served, second pending and served, third lost.
    start_read(500, 4, 1'b0);
    push_next();
    push_next();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.RD_STROBE = 1'b1;
      @(negedge CLK);
      bus.RD_STROBE = 1'b0;
    end
    repeat (20) @(negedge CLK);
    check("burst_overrun", int'(bus.Overrun), 1);
    check("burst_served", exp_data.size() + exp_addr.size(), 0);
    for (int i = 2; i < 4 * SPA; i++) begin
      strobe_and_wait(ok);
      if (!ok) break;
    end
    finish_window("burst");
    check("burst_overrun_sticky", int'(bus.Overrun), 1);

    // Reset while a fetch is in flight abandons the read.
    start_read(1000, 5, 1'b0);
    push_next();
    @(negedge CLK);
    bus.RD_STROBE = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge CLK);
      if (!bus.SRAM_OE_n) ok = 1'b1;
    end
    check("fetch_seen_before_reset", int'(ok), 1);
    nRST = 1'b0;
    bus.RD_STROBE = 1'b0;
    #1;
    check_reset_outputs("midread_reset");
    exp_data.delete();
    exp_addr.delete();
    repeat (2) @(negedge CLK);
    check_reset_outputs("held_reset");
    nRST = 1'b1;
    @(negedge CLK);
    read_window(1000, 5, 1'b0);

    // Randomised windows anywhere in the address space.
    for (int t = 0; t < 6; t++) begin
      read_window(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 8)), 1'b0);
    end
    read_window(DEPTH - 1, 3, 1'b0);

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
